// File: rtl/wb_arbiter_if.sv
// Bundles the execution-unit source bus, register-file write port and trap/retire signals.
// Pure wiring: the interface adds no latency.
// Sources hold their entries until src_ok; the arbiter never stalls downstream.
interface wb_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int N_SRC = 3,
  parameter int CNT_W = 64
);
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]      src_v;
  logic [N_SRC*XLEN-1:0] src_result;
  logic [N_SRC*5-1:0]    src_rd;
  logic [N_SRC-1:0]      src_exc;
  logic [N_SRC-1:0]      src_ok;
  logic                  rf_we;
  logic [4:0]            rf_waddr;
  logic [XLEN-1:0]       rf_wdata;
  logic                  exc_v;
  logic [SW-1:0]         exc_src;
  logic                  exc_ack;
  logic [CNT_W-1:0]      retire_cnt;

  // Source FIFOs and trap logic side
  modport master (
    output src_v, src_result, src_rd, src_exc, exc_ack,
    input  src_ok, rf_we, rf_waddr, rf_wdata, exc_v, exc_src, retire_cnt
  );

  // Write-back arbiter side
  modport slave (
    input  src_v, src_result, src_rd, src_exc, exc_ack,
    output src_ok, rf_we, rf_waddr, rf_wdata, exc_v, exc_src, retire_cnt
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: ALU/LSU/CSR results into one registered RF write port.
// src_ok is combinational; RF write, exception and retire count update 1 cycle after transfer.
// Pending exception stalls all grants until exc_ack; ungranted sources simply hold in their FIFOs.
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int N_SRC = 3,
  parameter int CNT_W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [SW-1:0]    rr_ptr;
  logic [SW:0]      cand;
  logic [SW-1:0]    cand_s;
  logic [SW-1:0]    gnt_idx;
  logic             gnt_any;
  logic             stall;
  logic             xfer;
  logic [N_SRC-1:0] gnt_oh;
  logic [4:0]       g_rd;
  logic [XLEN-1:0]  g_res;
  logic             g_exc;
  logic [SW-1:0]    ptr_nxt;

  logic             rf_we_q;
  logic [4:0]       rf_waddr_q;
  logic [XLEN-1:0]  rf_wdata_q;
  logic             exc_v_q;
  logic [SW-1:0]    exc_src_q;
  logic [CNT_W-1:0] retire_q;

  // Search for the first valid source starting at the rr pointer, wrapping modulo N_SRC
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    cand_s  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = {1'b0, rr_ptr} + (SW+1)'(k);
      if (cand >= (SW+1)'(N_SRC)) cand = cand - (SW+1)'(N_SRC);
      cand_s = cand[SW-1:0];
      if (!gnt_any && bus.src_v[cand_s]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_s;
      end
    end
  end

  // Gate the grant by the exception stall (an ack in the same cycle releases it) and by reset
  always_comb begin
    stall  = exc_v_q & ~bus.exc_ack;
    xfer   = gnt_any & ~stall & rst_n;
    gnt_oh = '0;
    if (xfer) gnt_oh[gnt_idx] = 1'b1;
  end

  // Mux out the granted source's payload and the post-grant pointer
  always_comb begin
    g_rd    = bus.src_rd[int'(gnt_idx)*5 +: 5];
    g_res   = bus.src_result[int'(gnt_idx)*XLEN +: XLEN];
    g_exc   = bus.src_exc[gnt_idx];
    ptr_nxt = (gnt_idx == SW'(N_SRC-1)) ? '0 : gnt_idx + SW'(1);
  end

  // Advance the rr pointer past the source that just transferred
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_ptr <= '0;
    else if (xfer) rr_ptr <= ptr_nxt;
  end

  // Register-file write port: one-cycle pulse, x0 writes dropped, address/data hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= xfer & ~g_exc & (g_rd != 5'd0);
      if (xfer && !g_exc && g_rd != 5'd0) begin
        rf_waddr_q <= g_rd;
        rf_wdata_q <= g_res;
      end
    end
  end

  // Sticky exception: a new excepting transfer wins over an ack in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_v_q   <= 1'b0;
      exc_src_q <= '0;
    end else if (xfer && g_exc) begin
      exc_v_q   <= 1'b1;
      exc_src_q <= gnt_idx;
    end else if (exc_v_q && bus.exc_ack) begin
      exc_v_q   <= 1'b0;
    end
  end

  // Retire counter counts every non-excepting commit, including rd=0, and wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                retire_q <= '0;
    else if (xfer && !g_exc)   retire_q <= retire_q + CNT_W'(1);
  end

  assign bus.src_ok     = gnt_oh;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.exc_v      = exc_v_q;
  assign bus.exc_src    = exc_src_q;
  assign bus.retire_cnt = retire_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a scoreboard for grants and RF writes.
// Counter width is reduced to 4 bits so the wrap is reachable quickly.
// Inputs change 1ns after posedge; the monitor samples on negedge.
module tb_wb_arbiter;
  logic clk;
  logic rst_n;

  wb_arbiter_if #(.XLEN(32), .N_SRC(3), .CNT_W(4)) bus ();

  wb_arbiter #(.XLEN(32), .N_SRC(3), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp;
  int n_err;
  int gq[$];
  logic [36:0] cq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_g(input int g);
    gq.push_back(g);
  endtask

  task automatic push_c(input logic [4:0] a, input logic [31:0] d);
    cq.push_back({a, d});
  endtask

  // Monitor: every grant and every RF write must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.src_ok != 3'b000) begin
        if (gq.size() == 0) begin
          check("unexpected_grant", {61'd0, bus.src_ok}, 64'd0);
        end else begin
          int g;
          logic [2:0] eo;
          g = gq.pop_front();
          eo = 3'b001 << g;
          check("grant", {61'd0, bus.src_ok}, {61'd0, eo});
        end
      end
      if (bus.rf_we) begin
        if (cq.size() == 0) begin
          check("unexpected_rf_we", {63'd0, bus.rf_we}, 64'd0);
        end else begin
          logic [36:0] e;
          e = cq.pop_front();
          check("rf_waddr", {59'd0, bus.rf_waddr}, {59'd0, e[36:32]});
          check("rf_wdata", {32'd0, bus.rf_wdata}, {32'd0, e[31:0]});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.src_v = '0;
    bus.src_result = '0;
    bus.src_rd = '0;
    bus.src_exc = '0;
    bus.exc_ack = 1'b0;

    // Reset state
    #2;
    check("rst_rf_we", {63'd0, bus.rf_we}, 64'd0);
    check("rst_rf_waddr", {59'd0, bus.rf_waddr}, 64'd0);
    check("rst_rf_wdata", {32'd0, bus.rf_wdata}, 64'd0);
    check("rst_exc_v", {63'd0, bus.exc_v}, 64'd0);
    check("rst_retire", {60'd0, bus.retire_cnt}, 64'd0);
    bus.src_v = 3'b111;
    #1;
    check("rst_src_ok", {61'd0, bus.src_ok}, 64'd0);
    bus.src_v = 3'b000;
    #9;
    rst_n = 1'b1;
    step();

    // Single ALU result
    bus.src_v = 3'b001;
    bus.src_rd = {5'd0, 5'd0, 5'd5};
    bus.src_result = {32'd0, 32'd0, 32'hDEADBEEF};
    push_g(0); push_c(5'd5, 32'hDEADBEEF);
    step();
    bus.src_v = 3'b000;
    check("single_retire", {60'd0, bus.retire_cnt}, 64'd1);
    step();

    // Round-robin from reset: all three valid for 6 cycles
    rst_n = 1'b0; #1; rst_n = 1'b1;
    bus.src_v = 3'b111;
    bus.src_rd = {5'd3, 5'd2, 5'd1};
    bus.src_result = {32'hA2, 32'hA1, 32'hA0};
    push_g(0); push_c(5'd1, 32'hA0);
    push_g(1); push_c(5'd2, 32'hA1);
    push_g(2); push_c(5'd3, 32'hA2);
    push_g(0); push_c(5'd1, 32'hA0);
    push_g(1); push_c(5'd2, 32'hA1);
    push_g(2); push_c(5'd3, 32'hA2);
    for (int i = 0; i < 6; i++) step();
    bus.src_v = 3'b000;
    check("rr_retire", {60'd0, bus.retire_cnt}, 64'd6);

    // Move pointer to 1, then only sources 0 and 2 valid: order 2,0,2
    bus.src_v = 3'b001;
    push_g(0); push_c(5'd1, 32'hA0);
    step();
    bus.src_v = 3'b101;
    push_g(2); push_c(5'd3, 32'hA2);
    push_g(0); push_c(5'd1, 32'hA0);
    push_g(2); push_c(5'd3, 32'hA2);
    for (int i = 0; i < 3; i++) step();
    bus.src_v = 3'b000;
    check("rr02_retire", {60'd0, bus.retire_cnt}, 64'd10);

    // x0 write suppressed but still retired
    bus.src_v = 3'b100;
    bus.src_rd = {5'd0, 5'd0, 5'd0};
    bus.src_result = {32'h1234, 32'd0, 32'd0};
    push_g(2);
    step();
    bus.src_v = 3'b000;
    check("x0_retire", {60'd0, bus.retire_cnt}, 64'd11);
    step();

    // LSU exception, then stall with ALU waiting
    bus.src_v = 3'b010;
    bus.src_exc = 3'b010;
    bus.src_rd = {5'd0, 5'd7, 5'd9};
    bus.src_result = {32'd0, 32'h77, 32'h55};
    push_g(1);
    step();
    bus.src_exc = 3'b000;
    bus.src_v = 3'b001;
    check("exc_v_set", {63'd0, bus.exc_v}, 64'd1);
    check("exc_src_lsu", {62'd0, bus.exc_src}, 64'd1);
    check("exc_retire_hold", {60'd0, bus.retire_cnt}, 64'd11);
    for (int i = 0; i < 3; i++) begin
      check("stall_src_ok", {61'd0, bus.src_ok}, 64'd0);
      step();
    end
    check("stall_exc_v", {63'd0, bus.exc_v}, 64'd1);
    bus.exc_ack = 1'b1;
    push_g(0); push_c(5'd9, 32'h55);
    step();
    bus.exc_ack = 1'b0;
    bus.src_v = 3'b000;
    check("ack_exc_v_clr", {63'd0, bus.exc_v}, 64'd0);
    check("ack_retire", {60'd0, bus.retire_cnt}, 64'd12);

    // Ack and a new exception in the same cycle: set wins, source updates
    bus.src_v = 3'b010;
    bus.src_exc = 3'b010;
    push_g(1);
    step();
    bus.src_v = 3'b000;
    bus.src_exc = 3'b000;
    check("exc2_src1", {62'd0, bus.exc_src}, 64'd1);
    bus.exc_ack = 1'b1;
    bus.src_v = 3'b100;
    bus.src_exc = 3'b100;
    push_g(2);
    step();
    bus.exc_ack = 1'b0;
    bus.src_v = 3'b000;
    bus.src_exc = 3'b000;
    check("setwins_exc_v", {63'd0, bus.exc_v}, 64'd1);
    check("setwins_exc_src", {62'd0, bus.exc_src}, 64'd2);
    check("setwins_retire", {60'd0, bus.retire_cnt}, 64'd12);
    bus.exc_ack = 1'b1;
    step();
    bus.exc_ack = 1'b0;
    check("final_ack_clr", {63'd0, bus.exc_v}, 64'd0);

    // 4-bit counter wrap after 16 commits from reset
    rst_n = 1'b0; #1; rst_n = 1'b1;
    bus.src_v = 3'b001;
    bus.src_rd = {5'd0, 5'd0, 5'd4};
    for (int i = 0; i < 16; i++) begin
      bus.src_result = {32'd0, 32'd0, 32'h100 + 32'(i)};
      push_g(0); push_c(5'd4, 32'h100 + 32'(i));
      step();
      if (i == 14) check("wrap_15", {60'd0, bus.retire_cnt}, 64'd15);
      if (i == 15) check("wrap_0", {60'd0, bus.retire_cnt}, 64'd0);
    end

    // Async reset mid-burst (pointer is 1 here)
    bus.src_v = 3'b111;
    bus.src_rd = {5'd3, 5'd2, 5'd1};
    bus.src_result = {32'hC2, 32'hC1, 32'hC0};
    push_g(1); push_c(5'd2, 32'hC1);
    step();
    push_g(2);
    step();
    rst_n = 1'b0;
    #1;
    check("arst_rf_we", {63'd0, bus.rf_we}, 64'd0);
    check("arst_rf_waddr", {59'd0, bus.rf_waddr}, 64'd0);
    check("arst_rf_wdata", {32'd0, bus.rf_wdata}, 64'd0);
    check("arst_exc_v", {63'd0, bus.exc_v}, 64'd0);
    check("arst_exc_src", {62'd0, bus.exc_src}, 64'd0);
    check("arst_retire", {60'd0, bus.retire_cnt}, 64'd0);
    check("arst_src_ok", {61'd0, bus.src_ok}, 64'd0);
    bus.src_v = 3'b000;
    #2;
    rst_n = 1'b1;
    step();
    step();

    check("grant_queue_drained", 64'(gq.size()), 64'd0);
    check("commit_queue_drained", 64'(cq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
